peg_pkt_sf_fifo: RTL and testbench

Store-and-forward packet FIFO placed directly upstream of any packet consumer that cannot tolerate errored or truncated packets.
- Accepts packetized words (sop/eop/valid/data/error, valid-ready handshake) on an ingress slave port.
- Buffers each packet and releases it on the egress master port only after its eop has been received clean.
- Discards errored, oversized or malformed packets, rewinds write space and counts drops.

---
 rtl/peg_pkt_sf_fifo.sv | 227 ++++++++++++++++++++++
 tb/tb_peg_pkt_sf_fifo.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peg_pkt_sf_fifo.sv
// Store-and-forward packet FIFO. Ingress packets are buffered speculatively and
// become visible to egress only once their eop arrives clean. Errored, oversized
// and malformed packets are dropped by rewinding the write pointer.
module peg_pkt_sf_fifo #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_W    = 8,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ingress_sop,
  input  logic                  ingress_eop,
  input  logic                  ingress_valid,
  input  logic [DATA_W-1:0]     ingress_data,
  input  logic                  ingress_error,
  output logic                  ingress_ready,
  output logic                  egress_sop,
  output logic                  egress_eop,
  output logic                  egress_valid,
  output logic [DATA_W-1:0]     egress_data,
  output logic                  egress_error,
  input  logic                  egress_ready,
  output logic [DEPTH_W:0]      pkt_cnt,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int DEPTH = 1 << DEPTH_W;
  localparam int PW    = DEPTH_W + 1;
  localparam int RW    = DATA_W + 2;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);

  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

  state_t                state_reg, state_next;
  logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]         commit_ptr_reg, commit_ptr_next;
  logic [PW-1:0]         commit_vis_reg;   // commit pointer as seen by the read side
  logic [PW-1:0]         fetch_ptr_reg;    // next RAM word to pull into the output pipe
  logic [PW-1:0]         rd_ptr_reg;       // retire pointer, advances on egress transfer
  logic                  err_reg, err_next;
  logic                  ready_reg;
  logic [DEPTH_W:0]      pkt_cnt_reg;
  logic [DROP_CNT_W-1:0] drop_cnt_reg;

  logic [RW-1:0]         mem [DEPTH];
  logic [RW-1:0]         ram_q_reg;
  logic                  ram_q_valid_reg;
  logic [RW-1:0]         ob_word_reg [2];
  logic [1:0]            ob_cnt_reg;

  logic                  acc, we, commit, pop, pop_eop, fetch;
  logic                  full_wr, full_cm;
  logic [DEPTH_W-1:0]    waddr;
  logic [RW-1:0]         wdata;
  logic [1:0]            drop_add;
  logic [2:0]            ob_occ_next;
  logic [DROP_CNT_W:0]   drop_sum;

  assign acc     = ingress_valid & ready_reg;
  assign wdata   = {ingress_sop, ingress_eop, ingress_data};
  // Space is only reclaimed once a word has actually left through egress.
  assign full_wr = (wr_ptr_reg - rd_ptr_reg) == PTR_FULL;
  assign full_cm = (commit_ptr_reg - rd_ptr_reg) == PTR_FULL;

  // Ingress next-state: write, commit, rewind and drop decisions per accepted word.
  always_comb begin
    state_next      = state_reg;
    wr_ptr_next     = wr_ptr_reg;
    commit_ptr_next = commit_ptr_reg;
    err_next        = err_reg;
    we              = 1'b0;
    waddr           = wr_ptr_reg[DEPTH_W-1:0];
    commit          = 1'b0;
    drop_add        = 2'd0;
    if (acc) begin
      if (ingress_sop) begin
        // A sop always restarts at the commit point; any open packet is abandoned.
        if (state_reg != IDLE) drop_add = 2'd1;
        wr_ptr_next = commit_ptr_reg;
        if (full_cm) begin
          if (ingress_eop) begin
            drop_add   = drop_add + 2'd1;
            state_next = IDLE;
          end else begin
            state_next = DROP;
          end
        end else begin
          we    = 1'b1;
          waddr = commit_ptr_reg[DEPTH_W-1:0];
          if (ingress_eop) begin
            state_next = IDLE;
            if (!ingress_error) begin
              commit          = 1'b1;
              wr_ptr_next     = commit_ptr_reg + PTR_ONE;
              commit_ptr_next = commit_ptr_reg + PTR_ONE;
            end else begin
              drop_add = drop_add + 2'd1;
            end
          end else begin
            state_next  = PKT;
            wr_ptr_next = commit_ptr_reg + PTR_ONE;
            err_next    = ingress_error;
          end
        end
      end else begin
        case (state_reg)
          PKT: begin
            if (ingress_eop) begin
              state_next = IDLE;
              if (!err_reg && !ingress_error && !full_wr) begin
                we              = 1'b1;
                commit          = 1'b1;
                wr_ptr_next     = wr_ptr_reg + PTR_ONE;
                commit_ptr_next = wr_ptr_reg + PTR_ONE;
              end else begin
                wr_ptr_next = commit_ptr_reg;
                drop_add    = 2'd1;
              end
            end else if (full_wr) begin
              // Oversized: rewind now, count the drop when the eop shows up.
              wr_ptr_next = commit_ptr_reg;
              state_next  = DROP;
            end else begin
              we          = 1'b1;
              wr_ptr_next = wr_ptr_reg + PTR_ONE;
              err_next    = err_reg | ingress_error;
            end
          end
          DROP: begin
            if (ingress_eop) begin
              drop_add   = 2'd1;
              state_next = IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Egress pipe control: fetch only when the output buffer is guaranteed a slot.
  assign pop         = (ob_cnt_reg != 2'd0) & egress_ready;
  assign pop_eop     = pop & ob_word_reg[0][RW-2];
  assign ob_occ_next = 3'(ob_cnt_reg) + 3'(ram_q_valid_reg) - 3'(pop);
  assign fetch       = (fetch_ptr_reg != commit_vis_reg) && (ob_occ_next <= 3'd1);
  assign drop_sum    = {1'b0, drop_cnt_reg} + (DROP_CNT_W+1)'(drop_add);

  // Packet storage: synchronous write, registered read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (fetch) ram_q_reg <= mem[fetch_ptr_reg[DEPTH_W-1:0]];
  end

  // Pointers, ingress state and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      wr_ptr_reg      <= '0;
      commit_ptr_reg  <= '0;
      commit_vis_reg  <= '0;
      fetch_ptr_reg   <= '0;
      rd_ptr_reg      <= '0;
      err_reg         <= 1'b0;
      ready_reg       <= 1'b0;
      ram_q_valid_reg <= 1'b0;
      pkt_cnt_reg     <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      wr_ptr_reg      <= wr_ptr_next;
      commit_ptr_reg  <= commit_ptr_next;
      commit_vis_reg  <= commit_ptr_reg;
      err_reg         <= err_next;
      ready_reg       <= 1'b1;
      ram_q_valid_reg <= fetch;
      if (fetch) fetch_ptr_reg <= fetch_ptr_reg + PTR_ONE;
      if (pop)   rd_ptr_reg    <= rd_ptr_reg + PTR_ONE;
      case ({commit, pop_eop})
        2'b10:   pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
        2'b01:   pkt_cnt_reg <= pkt_cnt_reg - 1'b1;
        default: ;
      endcase
      drop_cnt_reg <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end
  end

  // Two-entry output buffer; head entry drives egress and holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      ob_word_reg[0] <= '0;
      ob_word_reg[1] <= '0;
      ob_cnt_reg     <= 2'd0;
    end else begin
      case ({ram_q_valid_reg, pop})
        2'b11: begin
          if (ob_cnt_reg == 2'd2) begin
            ob_word_reg[0] <= ob_word_reg[1];
            ob_word_reg[1] <= ram_q_reg;
          end else begin
            ob_word_reg[0] <= ram_q_reg;
          end
        end
        2'b01: begin
          ob_word_reg[0] <= ob_word_reg[1];
          ob_cnt_reg     <= ob_cnt_reg - 2'd1;
        end
        2'b10: begin
          if (ob_cnt_reg == 2'd0) ob_word_reg[0] <= ram_q_reg;
          else                    ob_word_reg[1] <= ram_q_reg;
          ob_cnt_reg <= ob_cnt_reg + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign ingress_ready = ready_reg;
  assign egress_valid  = ob_cnt_reg != 2'd0;
  assign egress_sop    = egress_valid & ob_word_reg[0][RW-1];
  assign egress_eop    = egress_valid & ob_word_reg[0][RW-2];
  assign egress_data   = ob_word_reg[0][DATA_W-1:0];
  assign egress_error  = 1'b0;
  assign pkt_cnt       = pkt_cnt_reg;
  assign drop_cnt      = drop_cnt_reg;

endmodule

// File: tb/tb_peg_pkt_sf_fifo.sv
// Bench for peg_pkt_sf_fifo with a 16-word buffer: packet-level queue model,
// per-cycle output compare, and directed scenarios with literal expectations.
module tb_peg_pkt_sf_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ingress_sop = 1'b0, ingress_eop = 1'b0, ingress_valid = 1'b0, ingress_error = 1'b0;
  logic [DW-1:0] ingress_data = '0;
  logic          ingress_ready;
  logic          egress_sop, egress_eop, egress_valid, egress_error;
  logic [DW-1:0] egress_data;
  logic          egress_ready = 1'b1;
  logic [4:0]    pkt_cnt;
  logic [15:0]   drop_cnt;

  peg_pkt_sf_fifo #(.DATA_W(DW), .DEPTH_W(4), .DROP_CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .ingress_sop(ingress_sop), .ingress_eop(ingress_eop), .ingress_valid(ingress_valid),
    .ingress_data(ingress_data), .ingress_error(ingress_error), .ingress_ready(ingress_ready),
    .egress_sop(egress_sop), .egress_eop(egress_eop), .egress_valid(egress_valid),
    .egress_data(egress_data), .egress_error(egress_error), .egress_ready(egress_ready),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          s;
    logic          e;
    logic [DW-1:0] d;
  } w_t;

  int  total = 0;
  int  bad   = 0;
  w_t  exp_q[$];
  w_t  cur[$];
  int  m_mode = 0;   // 0 idle, 1 collecting, 2 discarding
  logic m_err = 1'b0;
  int  m_occ = 0;
  int  m_pkt = 0;
  int  m_drop = 0;
  logic m_ready = 1'b0;
  logic rst_seen = 1'b0;
  logic stall = 1'b0;
  logic [DW+1:0] st_word = '0;
  int  n_out = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_drop_inc();
    if (m_drop < 65535) m_drop++;
  endtask

  task automatic finish_pkt();
    if (!m_err) begin
      foreach (cur[i]) exp_q.push_back(cur[i]);
      m_pkt++;
    end else begin
      m_drop_inc();
      m_occ -= cur.size();
    end
    cur.delete();
    m_mode = 0;
  endtask

  // Packet-level rules applied to one accepted ingress word.
  task automatic model_word(input logic s, input logic e, input logic er, input logic [DW-1:0] d);
    w_t w;
    w.s = s; w.e = e; w.d = d;
    if (s) begin
      if (m_mode == 1) begin
        m_drop_inc();
        m_occ -= cur.size();
        cur.delete();
      end else if (m_mode == 2) begin
        m_drop_inc();
      end
      if (m_occ == DEPTH) begin
        if (e) begin m_drop_inc(); m_mode = 0; end
        else m_mode = 2;
      end else begin
        cur.push_back(w);
        m_occ++;
        m_err = er;
        if (e) finish_pkt();
        else m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (e) begin
        if (!m_err && !er && m_occ < DEPTH) begin
          cur.push_back(w);
          m_occ++;
          finish_pkt();
        end else begin
          m_drop_inc();
          m_occ -= cur.size();
          cur.delete();
          m_mode = 0;
        end
      end else if (m_occ == DEPTH) begin
        m_occ -= cur.size();
        cur.delete();
        m_mode = 2;
      end else begin
        cur.push_back(w);
        m_occ++;
        m_err = m_err | er;
      end
    end else if (m_mode == 2 && e) begin
      m_drop_inc();
      m_mode = 0;
    end
  endtask

  // Model update and egress scoreboard on pre-edge values.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      cur.delete();
      m_mode = 0; m_err = 1'b0; m_occ = 0; m_pkt = 0; m_drop = 0;
      m_ready = 1'b0; stall = 1'b0; rst_seen = 1'b1;
    end else begin
      logic fire;
      rst_seen = 1'b0;
      fire     = egress_valid && egress_ready;
      stall    = egress_valid && !egress_ready;
      st_word  = {egress_sop, egress_eop, egress_data};
      if (fire) begin
        n_out++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL egress_extra_word: got=%0h want=none t=%0t", egress_data, $time);
        end else begin
          w_t w;
          w = exp_q.pop_front();
          chk("egress_word", 32'({egress_sop, egress_eop, egress_data}), 32'({w.s, w.e, w.d}));
          if (w.e) m_pkt--;
        end
      end
      if (ingress_valid && m_ready)
        model_word(ingress_sop, ingress_eop, ingress_error, ingress_data);
      if (fire) m_occ--;
      m_ready = 1'b1;
    end
  end

  // Per-cycle compare of status outputs and stall stability.
  always @(negedge clk) begin
    chk("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("ingress_ready", 32'(ingress_ready), 32'(m_ready));
    chk("egress_error", 32'(egress_error), 32'd0);
    if (rst_seen) chk("rst_egress", 32'({egress_valid, egress_sop, egress_eop, egress_data}), 32'd0);
    if (stall) begin
      chk("stall_valid", 32'(egress_valid), 32'd1);
      chk("stall_word", 32'({egress_sop, egress_eop, egress_data}), 32'(st_word));
    end
  end

  task automatic send(input logic s, input logic e, input logic [DW-1:0] d, input logic er);
    @(negedge clk);
    ingress_valid = 1'b1; ingress_sop = s; ingress_eop = e; ingress_data = d; ingress_error = er;
  endtask

  task automatic idle_in();
    @(negedge clk);
    ingress_valid = 1'b0; ingress_sop = 1'b0; ingress_eop = 1'b0; ingress_error = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [DW-1:0] base, input int err_idx);
    for (int i = 0; i < n; i++)
      send(i == 0, i == n - 1, base + DW'(i), i == err_idx);
    idle_in();
  endtask

  task automatic drain();
    int cyc = 0;
    while ((exp_q.size() != 0 || egress_valid) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_in_time", 32'(cyc < 500), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int k;
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ingress_ready", 32'(ingress_ready), 32'd0);
    chk("reset_egress_valid", 32'(egress_valid), 32'd0);
    chk("reset_pkt_cnt", 32'(pkt_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(ingress_ready), 32'd1);

    // Clean 4-word packet: latency and back-to-back words
    send(1'b1, 1'b0, 16'h0001, 1'b0);
    send(1'b0, 1'b0, 16'h0002, 1'b0);
    send(1'b0, 1'b0, 16'h0003, 1'b0);
    send(1'b0, 1'b1, 16'h0004, 1'b0);
    idle_in();
    chk("s1_pkt_cnt_commit", 32'(pkt_cnt), 32'd1);
    chk("s1_valid_n0", 32'(egress_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("s1_valid_n2", 32'(egress_valid), 32'd0);
    @(negedge clk);
    chk("s1_valid_n3", 32'(egress_valid), 32'd1);
    chk("s1_first_word", 32'({egress_sop, egress_eop, egress_data}), 32'h20001);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      chk("s1_next_word", 32'({egress_valid, egress_data}), 32'h10000 | 32'(i));
    end
    chk("s1_last_eop", 32'(egress_eop), 32'd1);
    @(negedge clk);
    chk("s1_pkt_cnt_done", 32'(pkt_cnt), 32'd0);
    chk("s1_valid_done", 32'(egress_valid), 32'd0);

    // Errored packet dropped, clean one passes, space fully restored
    n0 = n_out;
    send_pkt(5, 16'h0010, 2);
    send_pkt(2, 16'h0020, -1);
    drain();
    chk("s2_words_out", 32'(n_out - n0), 32'd2);
    chk("s2_drop_cnt", 32'(drop_cnt), 32'd1);
    egress_ready = 1'b0;
    send_pkt(16, 16'h0030, -1);
    @(negedge clk);
    chk("s2_full16_pkt_cnt", 32'(pkt_cnt), 32'd1);
    chk("s2_full16_drop_cnt", 32'(drop_cnt), 32'd1);
    egress_ready = 1'b1;
    drain();

    // Overflow: 10 words commit, following 8-word packet is dropped
    egress_ready = 1'b0;
    n0 = n_out;
    send_pkt(10, 16'h0100, -1);
    send_pkt(8, 16'h0200, -1);
    @(negedge clk);
    chk("s3_pkt_cnt", 32'(pkt_cnt), 32'd1);
    chk("s3_drop_cnt", 32'(drop_cnt), 32'd2);
    egress_ready = 1'b1;
    drain();
    chk("s3_words_out", 32'(n_out - n0), 32'd10);

    // Sop inside an open packet aborts it; stray words in IDLE are ignored
    n0 = n_out;
    send(1'b1, 1'b0, 16'h0300, 1'b0);
    send(1'b0, 1'b0, 16'h0301, 1'b0);
    send_pkt(3, 16'h0310, -1);
    send(1'b0, 1'b0, 16'h0399, 1'b0);
    send(1'b0, 1'b1, 16'h039A, 1'b0);
    idle_in();
    drain();
    chk("s4_words_out", 32'(n_out - n0), 32'd3);
    chk("s4_drop_cnt", 32'(drop_cnt), 32'd3);

    // Toggling backpressure over a 6-word packet, then a single-word packet
    n0 = n_out;
    send_pkt(6, 16'h0600, -1);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      egress_ready = (i % 2 == 0);
    end
    egress_ready = 1'b1;
    drain();
    chk("s5_words_out", 32'(n_out - n0), 32'd6);
    send(1'b1, 1'b1, 16'h0055, 1'b0);
    idle_in();
    k = 0;
    while (!egress_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("s5_single_word", 32'({egress_valid, egress_sop, egress_eop, egress_data}), 32'h70055);
    drain();

    // Reset in the middle of egress with two packets held
    egress_ready = 1'b0;
    send_pkt(3, 16'h0400, -1);
    send_pkt(3, 16'h0410, -1);
    repeat (6) @(negedge clk);
    chk("s6_pkt_cnt_held", 32'(pkt_cnt), 32'd2);
    egress_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("s6_rst_state", 32'({egress_valid, ingress_ready, pkt_cnt, drop_cnt}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n0 = n_out;
    send_pkt(3, 16'h0500, -1);
    drain();
    chk("s6_words_out", 32'(n_out - n0), 32'd3);
    chk("s6_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
